// File: rtl/hazard_pkg.sv
// Shared opcodes and state encoding for the pipeline hazard/stall controller.
// The optional performance counters are enabled with HAZARD_PERF_CNT_EN.
package hazard_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_FLUSH,
    HZ_FREEZE
  } hz_state_t;

endpackage

// File: rtl/hazard_opdec.sv
// Combinational operand decoder: opcode class, register-use flags and register fields.
// The optional performance counters are enabled with HAZARD_PERF_CNT_EN.
module hazard_opdec
  import hazard_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic        o_is_load,
  output logic        o_is_store,
  output logic        o_uses_rs1,
  output logic        o_uses_rs2,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2
);

  logic [6:0] w_op;
  logic       w_unused;

  assign w_op       = i_ir[6:0];
  assign o_is_load  = (w_op == OP_LOAD);
  assign o_is_store = (w_op == OP_STORE);
  // Upper-immediate and jump-and-link forms carry immediate bits in the rs1 field.
  assign o_uses_rs1 = !((w_op == OP_LUI) || (w_op == OP_AUIPC) || (w_op == OP_JAL));
  assign o_uses_rs2 = (w_op == OP_RTYPE) || (w_op == OP_STORE) || (w_op == OP_BRANCH);
  assign o_rd       = i_ir[11:7];
  assign o_rs1      = i_ir[19:15];
  assign o_rs2      = i_ir[24:20];

  assign w_unused = ^{i_ir[31:25], i_ir[14:12]};

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use stall, taken-redirect squash, memory-wait freeze and timeout.
// Define HAZARD_PERF_CNT_EN to add the stall/flush performance counters.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_WAIT     = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_if_id_ir,
  input  logic [31:0] i_id_ex_ir,
  input  logic        i_br_taken,
  input  logic        i_mem_busy,
  output logic        o_pc_we,
  output logic        o_if_id_we,
  output logic        o_id_ex_we,
  output logic        o_if_id_flush,
  output logic        o_id_ex_bubble,
  output logic        o_mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
`endif
);

  localparam int unsigned    WAIT_W     = $clog2(MAX_WAIT + 2);
  localparam logic [WAIT_W-1:0] WAIT_SAT   = WAIT_W'(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [2:0]     FLUSH_INIT = 3'(FLUSH_CYCLES);

  hz_state_t         r_state, w_state_nx;
  hz_state_t         r_saved, w_saved_nx;
  logic [2:0]        r_flush_left, w_flush_left_nx;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_now;
  logic              r_timeout;
  logic              w_timeout_hit;
  logic              w_stall;

  logic       w_ifid_is_load, w_ifid_is_store, w_ifid_uses_rs1, w_ifid_uses_rs2;
  logic [4:0] w_ifid_rd, w_ifid_rs1, w_ifid_rs2;
  logic       w_idex_is_load, w_idex_is_store, w_idex_uses_rs1, w_idex_uses_rs2;
  logic [4:0] w_idex_rd, w_idex_rs1, w_idex_rs2;
  logic       w_rs1_hit, w_rs2_hit, w_load_use;
  logic       w_unused;

  hazard_opdec u_dec_if_id (
    .i_ir       (i_if_id_ir),
    .o_is_load  (w_ifid_is_load),
    .o_is_store (w_ifid_is_store),
    .o_uses_rs1 (w_ifid_uses_rs1),
    .o_uses_rs2 (w_ifid_uses_rs2),
    .o_rd       (w_ifid_rd),
    .o_rs1      (w_ifid_rs1),
    .o_rs2      (w_ifid_rs2)
  );

  hazard_opdec u_dec_id_ex (
    .i_ir       (i_id_ex_ir),
    .o_is_load  (w_idex_is_load),
    .o_is_store (w_idex_is_store),
    .o_uses_rs1 (w_idex_uses_rs1),
    .o_uses_rs2 (w_idex_uses_rs2),
    .o_rd       (w_idex_rd),
    .o_rs1      (w_idex_rs1),
    .o_rs2      (w_idex_rs2)
  );

  assign w_unused = ^{w_ifid_is_load, w_ifid_rd, w_idex_is_store, w_idex_uses_rs1,
                      w_idex_uses_rs2, w_idex_rs1, w_idex_rs2};

  // A store whose only dependency is its data operand gets the value through the store bypass.
  assign w_rs1_hit  = w_ifid_uses_rs1 && (w_idex_rd == w_ifid_rs1);
  assign w_rs2_hit  = w_ifid_uses_rs2 && !w_ifid_is_store && (w_idex_rd == w_ifid_rs2);
  assign w_load_use = w_idex_is_load && (w_idex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

  // Busy-cycle count including the current cycle, saturating so the counter never wraps.
  assign w_wait_now    = (r_wait_cnt == WAIT_SAT) ? WAIT_SAT : r_wait_cnt + 1'b1;
  assign w_timeout_hit = i_rst_n && i_mem_busy && (w_wait_now > WAIT_LIMIT);
  assign o_mem_timeout = r_timeout || w_timeout_hit;

  always_comb begin
    w_state_nx       = r_state;
    w_saved_nx       = r_saved;
    w_flush_left_nx  = r_flush_left;
    o_pc_we          = 1'b1;
    o_if_id_we       = 1'b1;
    o_id_ex_we       = 1'b1;
    o_if_id_flush    = 1'b0;
    o_id_ex_bubble   = 1'b0;
    w_stall          = 1'b0;

    if (!i_rst_n) begin
      o_pc_we        = 1'b0;
      o_if_id_we     = 1'b0;
      o_id_ex_we     = 1'b0;
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
    end else if (i_mem_busy) begin
      o_pc_we    = 1'b0;
      o_if_id_we = 1'b0;
      o_id_ex_we = 1'b0;
      if (r_state != HZ_FREEZE) begin
        w_saved_nx = r_state;
        w_state_nx = HZ_FREEZE;
      end
    end else begin
      unique case (r_state)
        HZ_RUN: begin
          if (i_br_taken) begin
            o_if_id_flush  = 1'b1;
            o_id_ex_bubble = 1'b1;
            if (FLUSH_CYCLES != 0) begin
              w_state_nx      = HZ_FLUSH;
              w_flush_left_nx = FLUSH_INIT;
            end
          end else if (w_load_use) begin
            o_pc_we        = 1'b0;
            o_if_id_we     = 1'b0;
            o_id_ex_bubble = 1'b1;
            w_stall        = 1'b1;
          end
        end
        HZ_FLUSH: begin
          o_if_id_flush   = 1'b1;
          w_flush_left_nx = r_flush_left - 3'd1;
          if (r_flush_left <= 3'd1) begin
            w_flush_left_nx = 3'd0;
            w_state_nx      = HZ_RUN;
          end
        end
        HZ_FREEZE: begin
          w_state_nx = r_saved;
        end
        default: begin
          w_state_nx = HZ_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= HZ_RUN;
      r_saved      <= HZ_RUN;
      r_flush_left <= 3'd0;
      r_wait_cnt   <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_saved      <= w_saved_nx;
      r_flush_left <= w_flush_left_nx;
      r_wait_cnt   <= i_mem_busy ? w_wait_now : '0;
      r_timeout    <= r_timeout || w_timeout_hit;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (o_if_id_flush) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  localparam int unsigned CNT_W_unused = CNT_W;
`endif

endmodule
